axil_register_bridge: RTL and testbench
=======================================

AXIL_REGISTER_BRIDGE -- requirements
Module: axil_register_bridge

Interface
REQ-001 SHALL have parameter BUSWIDTH, default 32, meaning data width; only 32 is supported.
REQ-002 SHALL have parameter REGS, default 4, meaning the number of implemented word registers (≥2).
REQ-003 SHALL have parameter ADDRESSWIDTH, default $clog2(REGS), meaning the word-address width.
REQ-004 SHALL have these ports (one clock; reset synchronous, active-low):
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- awvalid/awready  in/out  1/1  AXI4-Lite write address handshake
- awaddr  in  ADDRESSWIDTH+2  byte address
- wvalid/wready  in/out  1/1  write data handshake
- wdata  in  BUSWIDTH  write data
- wstrb  in  BUSWIDTH/8  byte strobes
- bvalid/bready  out/in  1/1  write response handshake
- bresp  out  2  write response code
- arvalid/arready  in/out  1/1  read address handshake
- araddr  in  ADDRESSWIDTH+2  byte address
- rvalid/rready  out/in  1/1  read response handshake
- rdata  out  BUSWIDTH  read data
- rresp  out  2  read response code
- av_read/av_write  out  1/1  one-cycle strobes to the downstream register adapter
- av_address  out  ADDRESSWIDTH  word address
- av_wdata  out  BUSWIDTH  write data
- av_read_valid  in  1  read data valid from the adapter
- av_rdata  in  BUSWIDTH  read data from the adapter

Function
REQ-005 SHALL implement the states IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT and RD_RESP; only IDLE asserts any ready signal.
REQ-006 In IDLE, SHALL accept a write only when awvalid and wvalid are both high, raising awready and wready together combinationally in that cycle.
REQ-007 In IDLE, SHALL accept a read when arvalid is high, raising arready combinationally in that cycle.
REQ-008 When a write and a read are both pending in IDLE, SHALL grant the type not served last; the last-served flag resets to "read", so the first contest goes to the write.
REQ-009 SHALL treat a transfer as in error when its address has a nonzero bit[1:0] or a word index ≥ REGS.
REQ-010 For a valid write, SHALL register the address and data and pulse av_write for exactly one cycle in WR_ISSUE, the cycle after acceptance, with av_address = awaddr[ADDRESSWIDTH+1:2] and av_wdata = wdata.
REQ-011 SHALL then, in WR_RESP, hold bvalid=1 and bresp=OKAY (00) until bready, and return to IDLE in the cycle after the handshake.
REQ-012 For a valid read, SHALL pulse av_read for one cycle in RD_ISSUE, then wait in RD_WAIT until av_read_valid=1.
REQ-013 SHALL capture av_rdata in the av_read_valid cycle, then in RD_RESP hold rvalid=1, rdata and rresp=OKAY until rready.
REQ-014 For an error transfer, SHALL issue no av strobe, go directly to WR_RESP or RD_RESP with SLVERR (10), and drive rdata=0 on an error read.
REQ-015 SHALL ignore av_read_valid in every state except RD_WAIT.
REQ-016 SHALL hold rdata, rresp and bresp stable while the corresponding valid is high and not yet handshaken.
REQ-017 SHALL never have more than one transaction outstanding; throughput is at most one transfer per 3 cycles (write) or per adapter latency + 3 cycles (read).

Reset
REQ-018 When reset_n=0 at a clk edge, SHALL enter IDLE and drive all of awready, wready, arready, bvalid, rvalid, av_read and av_write to 0, with bresp, rresp, rdata, av_address and av_wdata = 0.
REQ-019 A reset during any non-IDLE state SHALL abandon the transaction, generating no strobe or response afterwards; the last-served flag resets to "read".

Configuration
REQ-020 With macro AXIL_BRIDGE_STRB_CHECK_EN defined, a write whose wstrb is not all ones SHALL be an error per REQ-014 (SLVERR, no av_write).
REQ-021 Without AXIL_BRIDGE_STRB_CHECK_EN, wstrb SHALL be ignored, and every in-range, aligned write SHALL be performed as a full word.

Verification
REQ-022 Write awaddr=0x4, wdata=0xDEADBEEF -> av_write high for one cycle, one cycle after acceptance, with av_address=1 and av_wdata=0xDEADBEEF; then bvalid with bresp=00.
REQ-023 Read araddr=0x8 with adapter latency 2, returning 0x12345678 -> av_read pulse with av_address=2; then rvalid with rdata=0x12345678 and rresp=00, held while rready=0 for 3 cycles.
REQ-024 REGS=3, read araddr=0xC and write awaddr=0x2 -> no av strobes; rresp=10 with rdata=0, and bresp=10.
REQ-025 Write and read presented together in IDLE twice in a row -> the write is served first, then the read, then the write again (alternating).
REQ-026 Assert reset_n=0 in RD_WAIT, then raise av_read_valid after reset is released -> no rvalid, state IDLE; with STRB_CHECK_EN, wstrb=0x3 -> bresp=10 and no av_write.

Source files
------------

// File: rtl/axil_register_bridge.sv
// axil_register_bridge: AXI4-Lite slave that turns each transfer into one-cycle register-adapter strobes.
// Define AXIL_BRIDGE_STRB_CHECK_EN to answer writes with partial byte strobes with SLVERR.
module axil_register_bridge #(
    parameter int BUSWIDTH     = 32,
    parameter int REGS         = 4,
    parameter int ADDRESSWIDTH = $clog2(REGS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDRESSWIDTH+1:0] awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [BUSWIDTH-1:0]     wdata,
    input  logic [BUSWIDTH/8-1:0]   wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDRESSWIDTH+1:0] araddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [BUSWIDTH-1:0]     rdata,
    output logic [1:0]              rresp,
    output logic                    av_read,
    output logic                    av_write,
    output logic [ADDRESSWIDTH-1:0] av_address,
    output logic [BUSWIDTH-1:0]     av_wdata,
    input  logic                    av_read_valid,
    input  logic [BUSWIDTH-1:0]     av_rdata
);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [ADDRESSWIDTH:0] REGS_W = (ADDRESSWIDTH+1)'(REGS);

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP} state_t;

    state_t                  state_q, state_d;
    logic                    last_wr_q, last_wr_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [BUSWIDTH-1:0]     wdata_q, wdata_d;
    logic [BUSWIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    idle, grant_wr, grant_rd, wr_err, rd_err;

    function automatic logic addr_err(input logic [ADDRESSWIDTH+1:0] a);
        return (a[1:0] != 2'b00) || ({1'b0, a[ADDRESSWIDTH+1:2]} >= REGS_W);
    endfunction

`ifdef AXIL_BRIDGE_STRB_CHECK_EN
    assign wr_err = addr_err(awaddr) || (wstrb != '1);
`else
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb;
    assign wr_err = addr_err(awaddr);
`endif
    assign rd_err = addr_err(araddr);

    // Readies stay low while reset is held; contested grants go to the type not served last.
    assign idle     = (state_q == IDLE) && reset_n;
    assign grant_wr = idle && awvalid && wvalid && (!arvalid || !last_wr_q);
    assign grant_rd = idle && arvalid && !grant_wr;

    assign awready    = grant_wr;
    assign wready     = grant_wr;
    assign arready    = grant_rd;
    assign bvalid     = (state_q == WR_RESP);
    assign rvalid     = (state_q == RD_RESP);
    assign av_write   = (state_q == WR_ISSUE);
    assign av_read    = (state_q == RD_ISSUE);
    assign av_address = addr_q;
    assign av_wdata   = wdata_q;
    assign bresp      = bresp_q;
    assign rresp      = rresp_q;
    assign rdata      = rdata_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bresp_q   <= OKAY;
            rresp_q   <= OKAY;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    last_wr_d = 1'b1;
                    addr_d    = awaddr[ADDRESSWIDTH+1:2];
                    wdata_d   = wdata;
                    bresp_d   = wr_err ? SLVERR : OKAY;
                    state_d   = wr_err ? WR_RESP : WR_ISSUE;
                end else if (grant_rd) begin
                    last_wr_d = 1'b0;
                    addr_d    = araddr[ADDRESSWIDTH+1:2];
                    rresp_d   = rd_err ? SLVERR : OKAY;
                    rdata_d   = rd_err ? '0 : rdata_q;
                    state_d   = rd_err ? RD_RESP : RD_ISSUE;
                end
            end
            WR_ISSUE: state_d = WR_RESP;
            WR_RESP:  state_d = bready ? IDLE : WR_RESP;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (av_read_valid) begin
                    rdata_d = av_rdata;
                    rresp_d = OKAY;
                    state_d = RD_RESP;
                end
            end
            RD_RESP:  state_d = rready ? IDLE : RD_RESP;
            default:  state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axil_register_bridge.sv
// tb_axil_register_bridge: directed AXI4-Lite transfers checked cycle by cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_axil_register_bridge;
    localparam int REGS = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  awaddr, araddr, wstrb;
    logic [31:0] wdata, rdata, av_wdata, av_rdata;
    logic [1:0]  bresp, rresp, av_address;
    logic        av_read, av_write, av_read_valid;

    always #5 clk = ~clk;

    axil_register_bridge #(.BUSWIDTH(32), .REGS(REGS)) dut (
        .clk(clk), .reset_n(reset_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .av_read(av_read), .av_write(av_write), .av_address(av_address), .av_wdata(av_wdata),
        .av_read_valid(av_read_valid), .av_rdata(av_rdata)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    logic rst_edge = 1'b0;
    int lat = 2;

    logic [31:0] mem [0:3] = '{default: 32'h0};
    logic [31:0] shadow [0:3] = '{default: 32'h0};

    int avw_n = 0, avr_n = 0, rd_done = 0, wr_done = 0, rhold_n = 0, rvalid_n = 0;
    int last_avw_cyc = 0, last_wacc_cyc = 0;
    logic [31:0] last_avw_data = 0, last_rdata = 0;
    logic [1:0]  last_avw_addr = 0, last_avr_addr = 0, last_bresp = 0, last_rresp = 0;

    logic        busy = 1'b0, kind_wr = 1'b0, m_err = 1'b0, last_wr = 1'b0;
    int          acc_cyc = 0, resp_cyc = 0, free_cyc = 0;
    logic [1:0]  m_idx = 0, m_resp = 0;
    logic [31:0] m_wdata = 0, m_rdata = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_edge <= !reset_n;
    end

    // Model: one transfer in flight, write strobe one cycle after acceptance, response timing from the adapter.
    always @(negedge clk) begin
        logic e_bv, e_rv, e_aw, e_ar, idle;
        int a;
        if (rst_edge) begin
            busy = 1'b0;
            last_wr = 1'b0;
            free_cyc = 0;
            chk("rst_bvalid", bvalid, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_av_read", av_read, 0);
            chk("rst_av_write", av_write, 0);
            chk("rst_bresp", bresp, 0);
            chk("rst_rresp", rresp, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_av_address", av_address, 0);
            chk("rst_av_wdata", av_wdata, 0);
        end else begin
            e_bv = busy && kind_wr && cyc >= resp_cyc;
            e_rv = busy && !kind_wr && resp_cyc != 0 && cyc >= resp_cyc;
            chk("bvalid", bvalid, e_bv);
            chk("rvalid", rvalid, e_rv);
            chk("av_write", av_write, busy && kind_wr && !m_err && cyc == acc_cyc + 1);
            chk("av_read", av_read, busy && !kind_wr && !m_err && cyc == acc_cyc + 1);
            if (av_write) begin
                chk("av_address_wr", av_address, m_idx);
                chk("av_wdata", av_wdata, m_wdata);
            end
            if (av_read) chk("av_address_rd", av_address, m_idx);
            if (e_bv) chk("bresp", bresp, m_resp);
            if (e_rv) begin
                chk("rresp", rresp, m_resp);
                chk("rdata", rdata, m_rdata);
            end
            if (busy && !kind_wr && !m_err && resp_cyc == 0 && cyc >= acc_cyc + 2 && av_read_valid)
                resp_cyc = cyc + 1;
            if ((e_bv && bready) || (e_rv && rready)) begin
                busy = 1'b0;
                free_cyc = cyc + 1;
            end
        end
        if (av_write) begin
            avw_n++;
            last_avw_addr = av_address;
            last_avw_data = av_wdata;
            last_avw_cyc = cyc;
        end
        if (av_read) begin
            avr_n++;
            last_avr_addr = av_address;
        end
        if (rvalid) rvalid_n++;
        if (rvalid && !rready) rhold_n++;
        if (rvalid && rready) begin
            rd_done++;
            last_rdata = rdata;
            last_rresp = rresp;
        end
        if (bvalid && bready) begin
            wr_done++;
            last_bresp = bresp;
        end
        if (awready && awvalid && wvalid) last_wacc_cyc = cyc;
        idle = reset_n && !busy && cyc >= free_cyc;
        e_aw = idle && awvalid && wvalid && (!arvalid || !last_wr);
        e_ar = idle && arvalid && !e_aw;
        chk("awready", awready, e_aw);
        chk("wready", wready, e_aw);
        chk("arready", arready, e_ar);
        if (e_aw) begin
            a = int'(awaddr);
            busy = 1'b1;
            kind_wr = 1'b1;
            last_wr = 1'b1;
            acc_cyc = cyc;
            m_err = (a % 4 != 0) || (a / 4 >= REGS);
`ifdef AXIL_BRIDGE_STRB_CHECK_EN
            if (wstrb != 4'hF) m_err = 1'b1;
`endif
            m_idx = 2'(a / 4);
            m_wdata = wdata;
            m_resp = m_err ? 2'b10 : 2'b00;
            resp_cyc = cyc + (m_err ? 1 : 2);
            if (!m_err) shadow[a / 4] = wdata;
        end
        if (e_ar) begin
            a = int'(araddr);
            busy = 1'b1;
            kind_wr = 1'b0;
            last_wr = 1'b0;
            acc_cyc = cyc;
            m_err = (a % 4 != 0) || (a / 4 >= REGS);
            m_idx = 2'(a / 4);
            m_resp = m_err ? 2'b10 : 2'b00;
            m_rdata = m_err ? 32'h0 : shadow[a / 4];
            resp_cyc = m_err ? cyc + 1 : 0;
        end
    end

    // Register adapter: stores strobed writes, answers reads after lat cycles.
    initial begin
        logic [1:0] ra;
        av_read_valid = 1'b0;
        av_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (av_write) mem[av_address] = av_wdata;
            if (av_read) begin
                ra = av_address;
                repeat (lat) @(posedge clk);
                #1;
                av_read_valid = 1'b1;
                av_rdata = mem[ra];
                @(posedge clk);
                #1;
                av_read_valid = 1'b0;
                av_rdata = 32'h0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic ok;
        awaddr = addr;
        wdata = data;
        wstrb = strb;
        awvalid = 1'b1;
        wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = awready;
        end
        if (!ok) expire("aw_handshake");
        step();
        awvalid = 1'b0;
        wvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bvalid && bready;
        end
        if (!ok) expire("b_handshake");
        step();
    endtask

    task automatic do_read(input logic [3:0] addr, input int hold);
        logic ok;
        rready = (hold == 0);
        araddr = addr;
        arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = arready;
        end
        if (!ok) expire("ar_handshake");
        step();
        arvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = rvalid;
        end
        if (!ok) expire("r_valid");
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            rready = 1'b1;
            @(negedge clk);
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, r0, h0, rv0, rd0;
        logic order [$];
        logic ok;
        reset_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awaddr = 4'h0; araddr = 4'h0; wdata = 32'h0; wstrb = 4'hF;
        bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        w0 = avw_n;
        do_write(4'h4, 32'hDEADBEEF, 4'hF);
        chk("wr_strobe_count", avw_n - w0, 1);
        chk("wr_av_address", last_avw_addr, 1);
        chk("wr_av_wdata", last_avw_data, 32'hDEADBEEF);
        chk("wr_strobe_latency", last_avw_cyc - last_wacc_cyc, 1);
        chk("wr_bresp", last_bresp, 0);

        do_write(4'h8, 32'h12345678, 4'hF);
        r0 = avr_n;
        h0 = rhold_n;
        do_read(4'h8, 3);
        chk("rd_strobe_count", avr_n - r0, 1);
        chk("rd_av_address", last_avr_addr, 2);
        chk("rd_rdata", last_rdata, 32'h12345678);
        chk("rd_rresp", last_rresp, 0);
        chk("rd_held_cycles", rhold_n - h0, 3);

        w0 = avw_n;
        r0 = avr_n;
        do_read(4'hC, 0);
        chk("err_rd_rresp", last_rresp, 2);
        chk("err_rd_rdata", last_rdata, 0);
        do_write(4'h2, 32'h11111111, 4'hF);
        chk("err_wr_bresp", last_bresp, 2);
        chk("err_no_av_write", avw_n - w0, 0);
        chk("err_no_av_read", avr_n - r0, 0);

        lat = 6;
        r0 = avr_n;
        rv0 = rvalid_n;
        rd0 = rd_done;
        rready = 1'b1;
        araddr = 4'h4;
        arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = arready;
        end
        if (!ok) expire("rst_ar_handshake");
        step();
        arvalid = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (10) step();
        chk("rstwait_av_read_issued", avr_n - r0, 1);
        chk("rstwait_no_rvalid", rvalid_n - rv0, 0);
        chk("rstwait_no_response", rd_done - rd0, 0);
        lat = 2;

        awaddr = 4'h0; wdata = 32'hA5A50001; wstrb = 4'hF; araddr = 4'h4;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        for (int i = 0; i < 60 && order.size() < 3; i++) begin
            @(negedge clk);
            if (awready) order.push_back(1'b1);
            if (arready) order.push_back(1'b0);
        end
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        if (order.size() < 3) expire("contest_order");
        else begin
            chk("contest_first_is_write", order[0], 1);
            chk("contest_second_is_read", order[1], 0);
            chk("contest_third_is_write", order[2], 1);
        end
        repeat (6) step();
        chk("contest_read_data", last_rdata, 32'hDEADBEEF);

        w0 = avw_n;
        do_write(4'h8, 32'hCAFEF00D, 4'h3);
`ifdef AXIL_BRIDGE_STRB_CHECK_EN
        chk("strb_bresp", last_bresp, 2);
        chk("strb_no_av_write", avw_n - w0, 0);
        do_read(4'h8, 0);
        chk("strb_readback", last_rdata, 32'h12345678);
`else
        chk("strb_bresp", last_bresp, 0);
        chk("strb_av_write", avw_n - w0, 1);
        chk("strb_full_word", last_avw_data, 32'hCAFEF00D);
        do_read(4'h8, 0);
        chk("strb_readback", last_rdata, 32'hCAFEF00D);
`endif
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
